draw_scheduler: RTL and testbench

Job scheduler that sits between the command source (switch/key front end or host logic) and the Bresenham circle engine plus vga_adapter write port on the 160x120 display. It queues draw commands, launches the circle engine one job at a time, and forwards the engine's pixel stream to the vga_adapter with screen clipping. It also executes full-screen clear jobs itself, so that the circle engine and the clear sweep share the single framebuffer write port without conflict.

---
 rtl/draw_pkg.sv | 35 +++
 rtl/draw_cmd_fifo.sv | 66 ++++++
 rtl/draw_scheduler.sv | 160 ++++++++++++++++
 tb/tb_draw_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the draw job scheduler: command layout,
// op encoding, screen geometry and the scheduler state set.
package draw_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam int unsigned COORD_W  = 8;
  localparam int unsigned PIX_W    = 9;
  localparam int unsigned RADIUS_W = 5;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned VGA_X_W  = 8;
  localparam int unsigned VGA_Y_W  = 7;

  typedef enum logic {
    OP_CIRCLE = 1'b0,
    OP_CLEAR  = 1'b1
  } op_e;

  typedef struct packed {
    op_e                 op;
    logic [COORD_W-1:0]  cx;
    logic [COORD_W-1:0]  cy;
    logic [RADIUS_W-1:0] radius;
    logic [COLOUR_W-1:0] colour;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ENG,
    S_CLEAR
  } state_e;

endpackage

// File: rtl/draw_cmd_fifo.sv
// Command queue: dout is loaded on pop and held until the next pop, so it
// doubles as the scheduler's job register. head_op lets the caller dispatch
// on the same edge that pops.
module draw_cmd_fifo
  import draw_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  cmd_t                     din,
  input  logic                     pop,
  output cmd_t                     dout,
  output op_e                      head_op,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign level   = count;
  assign head_op = mem[rd_ptr].op;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Queues circle/clear jobs, launches the circle engine one job at a time,
// clips its pixel stream onto the 160x120 framebuffer and runs clear sweeps.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [COORD_W-1:0]  cmd_cx,
  input  logic [COORD_W-1:0]  cmd_cy,
  input  logic [RADIUS_W-1:0] cmd_radius,
  input  logic [COLOUR_W-1:0] cmd_colour,
  output logic                eng_start,
  output logic [COORD_W-1:0]  eng_cx,
  output logic [COORD_W-1:0]  eng_cy,
  output logic [RADIUS_W-1:0] eng_radius,
  input  logic                eng_pix_valid,
  input  logic [PIX_W-1:0]    eng_pix_x,
  input  logic [PIX_W-1:0]    eng_pix_y,
  input  logic                eng_done,
  output logic [VGA_X_W-1:0]  vga_x,
  output logic [VGA_Y_W-1:0]  vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic [7:0]          done_count
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam logic [PIX_W-1:0]   X_LIMIT = PIX_W'(SCREEN_W);
  localparam logic [PIX_W-1:0]   Y_LIMIT = PIX_W'(SCREEN_H);
  localparam logic [VGA_X_W-1:0] LAST_X  = VGA_X_W'(SCREEN_W - 1);
  localparam logic [VGA_Y_W-1:0] LAST_Y  = VGA_Y_W'(SCREEN_H - 1);

  state_e           state;
  cmd_t             cmd_in;
  cmd_t             job;
  op_e              head_op;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] level;
  logic             push;
  logic             pop;
  logic             on_screen;
  logic             clear_last;
  logic             active_next;
  logic             queued_next;

  assign cmd_in = '{op: op_e'(cmd_op), cx: cmd_cx, cy: cmd_cy,
                    radius: cmd_radius, colour: cmd_colour};

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;
  assign pop       = (state == S_IDLE) && !fifo_empty;

  draw_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .din     (cmd_in),
    .pop     (pop),
    .dout    (job),
    .head_op (head_op),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // The FIFO output register holds the popped job, so these stay registered.
  assign eng_cx     = job.cx;
  assign eng_cy     = job.cy;
  assign eng_radius = job.radius;
  assign vga_colour = job.colour;

  always_comb begin
    on_screen   = !eng_pix_x[PIX_W-1] && (eng_pix_x < X_LIMIT) &&
                  !eng_pix_y[PIX_W-1] && (eng_pix_y < Y_LIMIT);
    clear_last  = (vga_x == LAST_X) && (vga_y == LAST_Y);
    active_next = 1'b0;
    case (state)
      S_IDLE:     active_next = !fifo_empty;
      S_LAUNCH:   active_next = 1'b1;
      S_WAIT_ENG: active_next = !eng_done;
      S_CLEAR:    active_next = !clear_last;
      default:    active_next = 1'b0;
    endcase
    // Queue occupancy after this edge, accounting for a simultaneous pop.
    queued_next = push || (level > LVL_W'(1)) || ((level == LVL_W'(1)) && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      eng_start  <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      done_count <= '0;
    end else begin
      busy      <= active_next || queued_next;
      eng_start <= 1'b0;
      vga_plot  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            if (head_op == OP_CLEAR) begin
              state    <= S_CLEAR;
              vga_x    <= '0;
              vga_y    <= '0;
              vga_plot <= 1'b1;
            end else begin
              state     <= S_LAUNCH;
              eng_start <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT_ENG;
        end
        S_WAIT_ENG: begin
          if (eng_pix_valid && on_screen) begin
            vga_plot <= 1'b1;
            vga_x    <= eng_pix_x[VGA_X_W-1:0];
            vga_y    <= eng_pix_y[VGA_Y_W-1:0];
          end
          if (eng_done) begin
            done_count <= done_count + 8'd1;
            state      <= S_IDLE;
          end
        end
        S_CLEAR: begin
          // vga_x/vga_y double as the sweep position while clearing.
          if (clear_last) begin
            done_count <= done_count + 8'd1;
            state      <= S_IDLE;
          end else begin
            vga_plot <= 1'b1;
            if (vga_x == LAST_X) begin
              vga_x <= '0;
              vga_y <= vga_y + VGA_Y_W'(1);
            end else begin
              vga_x <= vga_x + VGA_X_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: reset, circle launch/pixel forwarding,
// clipping, full clear sweep, queue back-pressure and mid-job reset.
module tb_draw_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [7:0] cmd_cx;
  logic [7:0] cmd_cy;
  logic [4:0] cmd_radius;
  logic [2:0] cmd_colour;
  logic       eng_start;
  logic [7:0] eng_cx;
  logic [7:0] eng_cy;
  logic [4:0] eng_radius;
  logic       eng_pix_valid;
  logic [8:0] eng_pix_x;
  logic [8:0] eng_pix_y;
  logic       eng_done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic [7:0] done_count;

  int vectors     = 0;
  int miscompares = 0;

  draw_scheduler #(
    .DEPTH    (4),
    .SCREEN_W (160),
    .SCREEN_H (120)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_cx        (cmd_cx),
    .cmd_cy        (cmd_cy),
    .cmd_radius    (cmd_radius),
    .cmd_colour    (cmd_colour),
    .eng_start     (eng_start),
    .eng_cx        (eng_cx),
    .eng_cy        (eng_cy),
    .eng_radius    (eng_radius),
    .eng_pix_valid (eng_pix_valid),
    .eng_pix_x     (eng_pix_x),
    .eng_pix_y     (eng_pix_y),
    .eng_done      (eng_done),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_colour    (vga_colour),
    .vga_plot      (vga_plot),
    .busy          (busy),
    .done_count    (done_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Offer one command; returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic op, input logic [7:0] cx, input logic [7:0] cy,
                          input logic [4:0] r, input logic [2:0] col);
    int unsigned w;
    w          = 0;
    cmd_op     = op;
    cmd_cx     = cx;
    cmd_cy     = cy;
    cmd_radius = r;
    cmd_colour = col;
    cmd_valid  = 1'b1;
    while (!cmd_ready && w < 100) begin
      step();
      w++;
    end
    check("accept_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  logic [8:0]  px [4];
  logic [8:0]  py [4];
  logic [7:0]  cxs [5];
  int unsigned n, ex, ey, colour_bad, order_bad, w, plots, starts;
  logic [7:0]  lx;
  logic [6:0]  ly;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_cx = '0; cmd_cy = '0;
    cmd_radius = '0; cmd_colour = '0;
    eng_pix_valid = 1'b0; eng_pix_x = '0; eng_pix_y = '0; eng_done = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (10) step();

    // Reset / idle state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_vga_plot", vga_plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done_count", done_count, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_vga_colour", vga_colour, 0);

    // Circle (80,60) r=10 colour 3: start at N+2, pixels forwarded 1 cycle later
    send_cmd(1'b0, 8'd80, 8'd60, 5'd10, 3'd3);
    check("c1_start_early", eng_start, 0);
    check("c1_busy", busy, 1);
    step();
    check("c1_start", eng_start, 1);
    check("c1_cx", eng_cx, 80);
    check("c1_cy", eng_cy, 60);
    check("c1_radius", eng_radius, 10);
    check("c1_colour", vga_colour, 3);
    step();
    check("c1_start_pulse", eng_start, 0);
    px = '{9'd90, 9'd80, 9'd70, 9'd80};
    py = '{9'd60, 9'd70, 9'd60, 9'd50};
    for (int i = 0; i < 4; i++) begin
      eng_pix_valid = 1'b1;
      eng_pix_x = px[i];
      eng_pix_y = py[i];
      eng_done = (i == 3);
      step();
      check("c1_plot", vga_plot, 1);
      check("c1_x", vga_x, 32'(px[i]));
      check("c1_y", vga_y, 32'(py[i]));
    end
    eng_pix_valid = 1'b0; eng_done = 1'b0;
    check("c1_done_count", done_count, 1);
    check("c1_busy_fall", busy, 0);
    // Engine strobes while IDLE are ignored
    eng_pix_valid = 1'b1; eng_pix_x = 9'd5; eng_pix_y = 9'd5; eng_done = 1'b1;
    step();
    eng_pix_valid = 1'b0; eng_done = 1'b0;
    check("idle_pix_ignored", vga_plot, 0);
    check("idle_done_ignored", done_count, 1);

    // Clipping: circle at (2,2) r=5 colour 6
    send_cmd(1'b0, 8'd2, 8'd2, 5'd5, 3'd6);
    step();
    step();
    eng_pix_valid = 1'b1; eng_pix_x = 9'h1FD; eng_pix_y = 9'd2;
    step();
    check("clip_neg_x", vga_plot, 0);
    eng_pix_x = 9'd7; eng_pix_y = 9'd2;
    step();
    check("clip_in_plot", vga_plot, 1);
    check("clip_in_x", vga_x, 7);
    check("clip_in_y", vga_y, 2);
    check("clip_in_colour", vga_colour, 6);
    eng_pix_x = 9'd5; eng_pix_y = 9'd120;
    step();
    check("clip_y_120", vga_plot, 0);
    eng_pix_x = 9'd160; eng_pix_y = 9'd5; eng_done = 1'b1;
    step();
    eng_pix_valid = 1'b0; eng_done = 1'b0;
    check("clip_x_160", vga_plot, 0);
    check("clip_done_count", done_count, 2);

    // Full clear, colour 5
    send_cmd(1'b1, 8'd0, 8'd0, 5'd0, 3'd5);
    check("clr_no_early", vga_plot, 0);
    step();
    check("clr_first_plot", vga_plot, 1);
    check("clr_first_x", vga_x, 0);
    check("clr_first_y", vga_y, 0);
    n = 0; ex = 0; ey = 0; colour_bad = 0; order_bad = 0; lx = '0; ly = '0;
    while (vga_plot && n < 20000) begin
      if (32'(vga_x) != ex || 32'(vga_y) != ey) order_bad++;
      if (vga_colour != 3'd5) colour_bad++;
      lx = vga_x; ly = vga_y; n++;
      ex++;
      if (ex == 160) begin ex = 0; ey++; end
      step();
    end
    check("clr_len", n, 19200);
    check("clr_last_x", lx, 159);
    check("clr_last_y", ly, 119);
    check("clr_order_bad", order_bad, 0);
    check("clr_colour_bad", colour_bad, 0);
    check("clr_done_count", done_count, 3);
    check("clr_busy", busy, 0);

    // Back-pressure: J0 stalls the engine, four commands fill the queue
    send_cmd(1'b0, 8'd10, 8'd10, 5'd1, 3'd1);
    step();
    check("j0_start", eng_start, 1);
    step();
    cxs = '{8'd21, 8'd22, 8'd23, 8'd24, 8'd25};
    for (int i = 0; i < 4; i++) send_cmd(1'b0, cxs[i], 8'd30, 5'd0, 3'd2);
    check("full_after_four", cmd_ready, 0);
    cmd_op = 1'b0; cmd_cx = cxs[4]; cmd_cy = 8'd30; cmd_radius = '0; cmd_colour = 3'd2;
    cmd_valid = 1'b1;
    repeat (3) step();
    check("fifth_blocked", cmd_ready, 0);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    check("pop_cycle_still_full", cmd_ready, 0);
    step();
    check("ready_after_pop", cmd_ready, 1);
    for (int i = 0; i < 5; i++) begin
      w = 0;
      while (!eng_start && w < 20) begin step(); w++; end
      check("bp_start", eng_start, 1);
      check("bp_order_cx", eng_cx, 32'(cxs[i]));
      if (i > 0) check("bp_relaunch_gap", w, 1);
      step();
      cmd_valid = 1'b0;
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
    end
    check("bp_done_count", done_count, 9);
    check("bp_busy", busy, 0);

    // Reset in the middle of a clear with two jobs queued
    send_cmd(1'b1, 8'd0, 8'd0, 5'd0, 3'd2);
    send_cmd(1'b0, 8'd40, 8'd40, 5'd3, 3'd1);
    send_cmd(1'b0, 8'd50, 8'd50, 5'd3, 3'd1);
    w = 0;
    while (!(vga_plot && vga_x == 8'd20 && vga_y == 7'd3) && w < 2000) begin
      step();
      w++;
    end
    check("reach_pix500", {vga_plot, vga_y, vga_x}, {1'b1, 7'd3, 8'd20});
    rst = 1'b1;
    step();
    check("rst_mid_plot", vga_plot, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", cmd_ready, 1);
    check("rst_mid_done_count", done_count, 0);
    rst = 1'b0;
    plots = 0; starts = 0;
    repeat (40) begin
      step();
      if (vga_plot) plots++;
      if (eng_start) starts++;
    end
    check("post_rst_plots", plots, 0);
    check("post_rst_starts", starts, 0);
    check("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
